// File: rtl/pifo_sram_pkg.sv
// Shared types, constants and helpers for the PIFO level SRAM bank.
// Optional PIFO_SRAM_PARITY_EN adds per-slot even parity to the array.
package pifo_sram_pkg;

    localparam int PTW_DEF   = 16;
    localparam int MTW_DEF   = 0;
    localparam int CTW_DEF   = 10;
    localparam int DW_DEF    = MTW_DEF + PTW_DEF;
    localparam int PAR_MAX_W = 256;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    typedef struct packed {
        logic [CTW_DEF-1:0] cnt;
        logic [DW_DEF-1:0]  data;
    } slot_t;

    typedef struct packed {
        slot_t s1;
        slot_t s0;
    } entry_t;

    localparam slot_t EMPTY_SLOT = '{
        cnt:  '0,
        data: DW_DEF'({PTW_DEF{1'b1}})
    };

    localparam entry_t EMPTY_ENTRY = '{
        s1: EMPTY_SLOT,
        s0: EMPTY_SLOT
    };

    // Zero extension leaves even parity unchanged.
    function automatic logic slot_par(
        input logic [PAR_MAX_W-1:0] s
    );
        return ^s;
    endfunction

endpackage

// File: rtl/pifo_sram_array.sv
// Plain 1R1W synchronous array: registered read, no bypass.
// Kept bare so it can be replaced by a foundry macro.
module pifo_sram_array #(
    parameter int AW = 6,
    parameter int W  = 52
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/pifo_sram_bank.sv
// SRAM responder for one PIFO level: init sweep, write-first bypass.
// Define PIFO_SRAM_PARITY_EN for per-slot parity on the array.
module pifo_sram_bank
    import pifo_sram_pkg::*;
#(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int CTW      = 10,
    parameter int SRAM_ADW = 6,
    localparam int EW      = 2 * (CTW + MTW + PTW)
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_read,
    input  logic [SRAM_ADW-1:0] i_read_addr,
    output logic [EW-1:0]       o_read_data,
    input  logic                i_write,
    input  logic [SRAM_ADW-1:0] i_write_addr,
    input  logic [EW-1:0]       i_write_data,
    output logic                o_init_done,
    output logic                o_parity_err
);

    localparam int DW    = MTW + PTW;
    localparam int SW    = CTW + DW;
    localparam int DEPTH = 1 << SRAM_ADW;

    localparam logic [SW-1:0] EMPTY_SW = {
        {CTW{1'b0}}, DW'({PTW{1'b1}})
    };
    localparam logic [EW-1:0] EMPTY_EW = {2{EMPTY_SW}};

`ifdef PIFO_SRAM_PARITY_EN
    localparam int AWID = EW + 2;
`else
    localparam int AWID = EW;
`endif

    state_e              state_q, state_d;
    logic [SRAM_ADW-1:0] ptr_q, ptr_d;
    logic                done_q;
    logic                rvalid_q;
    logic                hit_q;
    logic [EW-1:0]       byp_q;

    logic                we;
    logic [SRAM_ADW-1:0] waddr;
    logic [EW-1:0]       wentry;
    logic [AWID-1:0]     wword;
    logic [AWID-1:0]     rword;
    logic                rd_en;
    logic                hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = ptr_q;
        wentry  = EMPTY_EW;
        unique case (state_q)
            ST_INIT: begin
                we    = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == SRAM_ADW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                we     = i_write;
                waddr  = i_write_addr;
                wentry = i_write_data;
            end
        endcase
    end

    assign rd_en = (state_q == ST_READY) & i_read;
    assign hit   = i_write & (i_write_addr == i_read_addr);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            byp_q    <= EMPTY_EW;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= (state_d == ST_READY);
            if (rd_en) begin
                rvalid_q <= 1'b1;
                hit_q    <= hit;
                if (hit) begin
                    byp_q <= i_write_data;
                end
            end
        end
    end

`ifdef PIFO_SRAM_PARITY_EN
    function automatic logic [1:0] ent_par(
        input logic [EW-1:0] e
    );
        return {
            slot_par(PAR_MAX_W'(e[EW-1:SW])),
            slot_par(PAR_MAX_W'(e[SW-1:0]))
        };
    endfunction

    assign wword = {ent_par(wentry), wentry};
    // Bypassed data never went through the array, so it is clean.
    assign o_parity_err = rvalid_q & ~hit_q &
        (rword[EW+1:EW] != ent_par(rword[EW-1:0]));
`else
    assign wword        = wentry;
    assign o_parity_err = 1'b0;
`endif

    pifo_sram_array #(
        .AW (SRAM_ADW),
        .W  (AWID)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wword),
        .i_re    (rd_en),
        .i_raddr (i_read_addr),
        .o_rdata (rword)
    );

    assign o_read_data = !rvalid_q ? EMPTY_EW :
                         hit_q     ? byp_q    :
                                     rword[EW-1:0];
    assign o_init_done = done_q;

endmodule

// File: tb/tb_pifo_sram_bank.sv
// Scoreboard bench for pifo_sram_bank against an array model.
// Define PIFO_SRAM_PARITY_EN to also exercise the parity check.
module tb_pifo_sram_bank;

    localparam int PTW   = 16;
    localparam int MTW   = 0;
    localparam int CTW   = 10;
    localparam int ADW   = 6;
    localparam int DEPTH = 1 << ADW;
    localparam int EW    = 2 * (CTW + MTW + PTW);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rd = 1'b0;
    logic [ADW-1:0] ra = '0;
    logic           wr = 1'b0;
    logic [ADW-1:0] wa = '0;
    logic [EW-1:0]  wd = '0;
    logic [EW-1:0]  rdata;
    logic           done;
    logic           perr;

    always #5 clk = ~clk;

    pifo_sram_bank #(
        .PTW      (PTW),
        .MTW      (MTW),
        .CTW      (CTW),
        .SRAM_ADW (ADW)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (rst_n),
        .i_read       (rd),
        .i_read_addr  (ra),
        .o_read_data  (rdata),
        .i_write      (wr),
        .i_write_addr (wa),
        .i_write_data (wd),
        .o_init_done  (done),
        .o_parity_err (perr)
    );

    typedef struct packed {
        logic [EW-1:0] d;
        logic          p;
    } exp_t;

    exp_t          q[$];
    logic [EW-1:0] mdl [DEPTH];
    int            init_cnt = 0;
    int            tests = 0;
    int            fails = 0;

    function automatic logic [EW-1:0] mk(
        int c1, int d1, int c0, int d0
    );
        return {CTW'(c1), PTW'(d1), CTW'(c0), PTW'(d0)};
    endfunction

    logic [EW-1:0] EMPTY;
    initial EMPTY = mk(0, 'hFFFF, 0, 'hFFFF);

    function automatic void chk(
        string n, logic [63:0] act, logic [63:0] exp
    );
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t",
                     n, act, exp, $time);
        end
    endfunction

    // Model: the array is swept to EMPTY on every reset.
    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = EMPTY;
    endtask

    task automatic cycle(
        input bit            r,
        input logic [ADW-1:0] a_r,
        input bit            w,
        input logic [ADW-1:0] a_w,
        input logic [EW-1:0] d,
        input bit            pe = 1'b0
    );
        exp_t e;
        @(negedge clk);
        rd = r; ra = a_r; wr = w; wa = a_w; wd = d;
        if (init_cnt >= DEPTH) begin
            if (r) begin
                e.d = (w && a_w == a_r) ? d : mdl[a_r];
                e.p = pe;
                q.push_back(e);
            end
            if (w) mdl[a_w] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, '0, 0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(EMPTY));
        chk("rst_perr", 64'(perr), 64'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [EW-1:0] last;
    logic          lastp;
    logic          have = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        bit   fire;
        if (!rst_n) begin
            init_cnt = 0;
            have = 1'b0;
            q.delete();
        end else begin
            fire = rd && (init_cnt >= DEPTH);
            if (init_cnt < 100000) init_cnt++;
            #1;
            chk("init_done", 64'(done),
                64'(init_cnt >= DEPTH));
            if (fire) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    last = e.d;
                    lastp = e.p;
                    have = 1'b1;
                end
            end
            chk("rdata", 64'(rdata),
                64'(have ? last : EMPTY));
            chk("perr", 64'(perr),
                64'(have ? lastp : 1'b0));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails + 1);
        $fatal(1, "timeout");
    end

    logic [EW-1:0] x;

    initial begin
        clear_model();
        rd = 1'b1; ra = 6'd5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 6'd5, 1, 6'd5, EW'({$urandom, $urandom}));
        for (int a = 0; a < DEPTH; a++)
            cycle(1, ADW'(a), 0, '0, '0);
        idle(2);

        x = mk(2, 40, 1, 7);
        cycle(0, '0, 1, 6'd3, x);
        cycle(1, 6'd3, 0, '0, '0);
        idle(3);

        x = mk(5, 'h1234, 3, 'hBEEF);
        cycle(1, 6'd9, 1, 6'd9, x);
        idle(1);
        cycle(1, 6'd10, 1, 6'd9, mk(1, 2, 3, 4));
        cycle(1, 6'd9, 0, '0, '0);
        idle(2);

`ifdef PIFO_SRAM_PARITY_EN
        @(negedge clk);
        dut.u_array.mem_q[12][0] = ~dut.u_array.mem_q[12][0];
        mdl[12][0] = ~mdl[12][0];
        cycle(1, 6'd12, 0, '0, '0, 1'b1);
        idle(2);
`else
        cycle(1, 6'd12, 0, '0, '0);
`endif
        cycle(1, 6'd13, 0, '0, '0);
        idle(1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, ADW'($urandom % 16),
                  $urandom_range(0, 1) == 1, ADW'($urandom % 16),
                  EW'({$urandom, $urandom}));
        idle(2);

        pulse_reset();
        idle(20);
        pulse_reset();
        for (int i = 0; i < DEPTH + 8; i++)
            cycle(1, ADW'($urandom), 0, '0, '0);
        idle(3);

        chk("sb_drain", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
